// File: rtl/muldiv_defs.sv
// muldiv_defs: shared op encodings, FSM states and default width for the multiply/divide unit
package muldiv_defs;
    localparam int N_DEF = 32;
    typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: operand magnitudes on entry and sign correction of the 2N result at completion
module muldiv_signfix
    import muldiv_defs::*;
#(
    parameter int N = N_DEF
) (
    input  logic           sgn,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           sa,
    output logic           sb,
    output logic [N-1:0]   ma,
    output logic [N-1:0]   mb,
    input  logic           is_div,
    input  logic           fa,
    input  logic           fb,
    input  logic [2*N-1:0] acc,
    output logic [N-1:0]   hi,
    output logic [N-1:0]   lo
);
    logic [2*N-1:0] prod;
    always_comb begin
        sa = sgn & a[N-1];
        sb = sgn & b[N-1];
        ma = sa ? -a : a;
        mb = sb ? -b : b;
        prod = (fa ^ fb) ? -acc : acc;
        hi = is_div ? (fa ? -acc[2*N-1:N] : acc[2*N-1:N]) : prod[2*N-1:N];
        lo = is_div ? ((fa ^ fb) ? -acc[N-1:0] : acc[N-1:0]) : prod[N-1:0];
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO; MULDIV_FAST_MUL_EN selects a single-cycle multiply
module muldiv_unit
    import muldiv_defs::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_zero
);
    localparam int CW = $clog2(N);
    state_t state;
    logic [2*N-1:0] acc;
    logic [N-1:0] opb, a_orig, ma, mb, res_hi, res_lo;
    logic [CW-1:0] cnt;
    logic is_div, dz, fa, fb, sa, sb;
    logic [N:0] add_sum, sub_cand, sub_diff;

    muldiv_signfix #(.N(N)) u_signfix (
        .sgn(!op[0]), .a(A), .b(B), .sa(sa), .sb(sb), .ma(ma), .mb(mb),
        .is_div(is_div), .fa(fa), .fb(fb), .acc(acc), .hi(res_hi), .lo(res_lo)
    );

    // acc holds {partial, multiplier} when multiplying and {remainder, quotient} when dividing
    assign add_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opb} : '0);
    assign sub_cand = acc[2*N-1:N-1];
    assign sub_diff = sub_cand - {1'b0, opb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            hi <= '0;
            lo <= '0;
            div_zero <= 1'b0;
            acc <= '0;
            opb <= '0;
            a_orig <= '0;
            cnt <= '0;
            is_div <= 1'b0;
            dz <= 1'b0;
            fa <= 1'b0;
            fb <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush && state != IDLE) begin
                state <= IDLE;
                busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !flush) begin
                        is_div <= op[1];
                        fa <= sa;
                        fb <= sb;
                        opb <= op[1] ? mb : ma;
                        dz <= op[1] && B == '0;
                        a_orig <= A;
                        div_zero <= 1'b0;
                        busy <= 1'b1;
                        cnt <= CW'(N - 1);
`ifdef MULDIV_FAST_MUL_EN
                        acc <= op[1] ? {{N{1'b0}}, ma} : (2*N)'(ma) * (2*N)'(mb);
                        state <= op[1] ? CALC : FIX;
`else
                        acc <= {{N{1'b0}}, op[1] ? ma : mb};
                        state <= CALC;
`endif
                    end
                    CALC: begin
                        acc <= is_div ? (sub_diff[N] ? {sub_cand[N-1:0], acc[N-2:0], 1'b0}
                                                     : {sub_diff[N-1:0], acc[N-2:0], 1'b1})
                                      : {add_sum, acc[N-1:1]};
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= FIX;
                    end
                    FIX: begin
                        hi <= dz ? a_orig : res_hi;
                        lo <= dz ? '1 : res_lo;
                        div_zero <= dz;
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus flush, start-while-busy and async reset sequences
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [1:0] op = 2'b00;
    logic [31:0] A = '0, B = '0;
    logic busy, done, div_zero;
    logic [31:0] hi, lo;
    int errors = 0, checks = 0;

    muldiv_unit #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
    } vec_t;
    vec_t v[11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int spur, input int fl, input int lim, output int cyc, output int bc);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        bc = int'(busy);
        while (!done && cyc < lim) begin
            start = (cyc == spur);
            if (cyc == spur) op = 2'b01;
            flush = (cyc == fl);
            @(posedge clk); #1;
            start = 1'b0;
            flush = 1'b0;
            cyc++;
            bc += int'(busy);
        end
    endtask

    initial begin
        int cyc, bc, lat;
        v[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        v[1]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        v[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        v[3]  = '{2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
        v[4]  = '{2'b11, 32'd9,        32'd4,        32'd1,        32'd2,        1'b0};
        v[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        v[6]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        v[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        v[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};
        v[9]  = '{2'b11, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0};
        v[10] = '{2'b01, 32'd6,        32'd7,        32'd0,        32'd42,       1'b0};

        repeat (3) @(posedge clk);
        #1 chk("reset_state", {busy, done, div_zero, hi, lo}, '0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            lat = v[i].op[1] ? DIV_LAT : MUL_LAT;
            run(v[i].op, v[i].a, v[i].b, -1, -1, 100, cyc, bc);
            chk($sformatf("v%0d_hi", i), hi, v[i].hi);
            chk($sformatf("v%0d_lo", i), lo, v[i].lo);
            chk($sformatf("v%0d_dz", i), div_zero, v[i].dz);
            chk($sformatf("v%0d_latency", i), cyc, lat);
            chk($sformatf("v%0d_busy_cycles", i), bc, lat - 1);
        end
        @(posedge clk); #1 chk("done_one_cycle", done, 1'b0);

        // second start at cycle 5 must not disturb DIV 100/7
        run(2'b10, 32'd100, 32'd7, 5, -1, 100, cyc, bc);
        chk("spur_lo", lo, 32'd14);
        chk("spur_hi", hi, 32'd2);
        chk("spur_latency", cyc, DIV_LAT);

        // flush at cycle 10: busy drops, no done, hi/lo untouched
        run(2'b11, 32'd1000, 32'd3, -1, 10, 50, cyc, bc);
        chk("flush_no_done", cyc, 50);
        chk("flush_busy_cycles", bc, 10);
        chk("flush_hi_lo", {hi, lo}, {32'd2, 32'd14});

        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; A = 32'd3; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_idle", busy, 1'b0);

        run(2'b01, 32'd6, 32'd7, -1, -1, 100, cyc, bc);
        chk("fresh_multu", {hi, lo}, {32'd0, 32'd42});
        chk("fresh_latency", cyc, MUL_LAT);

        @(negedge clk);
        start = 1'b1; op = 2'b00; A = 32'h12345; B = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", {busy, done, div_zero, hi, lo}, '0);
        @(negedge clk) rst_n = 1'b1;
        run(2'b11, 32'd20, 32'd3, -1, -1, 100, cyc, bc);
        chk("post_reset_divu", {hi, lo}, {32'd2, 32'd6});
        chk("post_reset_latency", cyc, DIV_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
